// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - round-robin arbiter sharing one SPI command channel and its TX/RX FIFOs
// Optional busy watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arbiter #(
  parameter int DATA    = 8,
  parameter int NREQ    = 2,
  parameter int LENW    = 16,
  parameter int TIMEOUT = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_op,
  input  logic [NREQ*LENW-1:0] req_len,
  input  logic [NREQ-1:0]      req_go,
  input  logic [NREQ*DATA-1:0] req_wdata,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [NREQ-1:0]      req_rd,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic [DATA-1:0]      rdata_out,
  output logic                 empty_out,
  output logic                 full_out,
  output logic [DATA-1:0]      wdata,
  output logic                 wr,
  input  logic                 full,
  output logic                 rd,
  input  logic [DATA-1:0]      rdata,
  input  logic                 empty,
  output logic [LENW-1:0]      len,
  output logic                 op,
  output logic                 work,
  input  logic                 busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_ARM, S_RUN, S_HOLD} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d, g_q, g_d;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic            err_q, err_d, wr_q, wr_d, rd_q, rd_d, work_q, work_d, op_q, op_d;
  logic [DATA-1:0] wdata_q, wdata_d;
  logic [LENW-1:0] len_q, len_d;
  logic [LENW-1:0] sel_len;
  logic            found;
  logic [IW-1:0]   win, cand;
`ifdef SPI_ARB_TIMEOUT_EN
  logic [31:0]     cnt_q, cnt_d;
`else
  logic            unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  assign sel_len = req_len[int'(g_q)*LENW +: LENW];

  // Search begins just after the last served requester, so it ends up lowest priority.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = err_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    work_d  = 1'b0;
    op_d    = op_q;
    len_d   = len_q;
    wdata_d = wdata_q;
`ifdef SPI_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          g_d     = win;
          gnt_d   = NREQ'(1) << win;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        wr_d    = req_wr[g_q] & ~full;
        wdata_d = req_wdata[int'(g_q)*DATA +: DATA];
        rd_d    = req_rd[g_q] & ~empty;
        if (req_go[g_q]) begin
          len_d = sel_len;
          op_d  = req_op[g_q];
          if (sel_len == '0) begin
            err_d   = 1'b1;
            done_d  = gnt_q;
            state_d = S_HOLD;
          end else begin
            work_d  = 1'b1;
            state_d = S_START;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end else if (!req[g_q]) begin
          gnt_d   = '0;
          wr_d    = 1'b0;
          rd_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_START: begin
        state_d = S_ARM;
`ifdef SPI_ARB_TIMEOUT_EN
        cnt_d   = cnt_q + 32'd1;
`endif
      end
      S_ARM, S_RUN: begin
        if (state_q == S_ARM && busy) begin
          state_d = S_RUN;
        end
        if (state_q == S_RUN && !busy) begin
          err_d   = 1'b0;
          done_d  = gnt_q;
          state_d = S_HOLD;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 32'd1;
        // Watchdog: a stuck busy ends the transaction as an error.
        if (cnt_q + 32'd1 >= 32'(TIMEOUT)) begin
          err_d   = 1'b1;
          done_d  = gnt_q;
          state_d = S_HOLD;
        end
`endif
      end
      S_HOLD: begin
        if (!req[g_q]) begin
          gnt_d   = '0;
          err_d   = 1'b0;
          ptr_d   = g_q;
          state_d = S_IDLE;
        end else begin
          rd_d = req_rd[g_q] & ~empty;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      work_q  <= 1'b0;
      op_q    <= 1'b0;
      len_q   <= '0;
      wdata_q <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      work_q  <= work_d;
      op_q    <= op_d;
      len_q   <= len_d;
      wdata_q <= wdata_d;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign wr        = wr_q;
  assign rd        = rd_q;
  assign work      = work_q;
  assign op        = op_q;
  assign len       = len_q;
  assign wdata     = wdata_q;
  assign rdata_out = rdata;
  // With no grant the FIFOs look unusable to every requester.
  assign empty_out = (|gnt_q) ? empty : 1'b1;
  assign full_out  = (|gnt_q) ? full : 1'b1;

endmodule
